// File: rtl/lsu.sv
// lsu: load/store unit driving a one-cycle combinational memory port; `LSU_MISALIGN_CHECK_EN adds misalignment traps.
// Result 2+LAT cycles after accept (1 for non-memory/trapped ops); in_ready low while busy, result held until out_ready.
module lsu #(
    parameter int unsigned LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_exc,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } req_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t      r_state;
    state_t      w_next;
    req_t        r_req;
    logic [3:0]  r_cnt;
    logic [31:0] r_data;
    logic        r_exc;
    logic        w_accept;
    logic        w_is_mem;
    logic        w_misalign;
    logic [15:0] w_lane;
    logic [31:0] w_load_val;

    assign w_is_mem = in_load | in_store;
    assign w_accept = in_valid & in_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = w_is_mem & (in_funct3[1] ? (in_addr[1:0] != 2'b00) : (in_funct3[0] & in_addr[0]));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid & ~rst) begin
                    w_next = (w_is_mem & ~w_misalign) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                mem_en = 1'b1;
                mem_wr = r_req.store;
                w_next = (LAT == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Stores and traps settle out_data at accept; loads overwrite it in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= '0;
            r_cnt  <= 4'd0;
            r_data <= 32'd0;
            r_exc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req  <= '{store: in_store, funct3: in_funct3, addr: in_addr, wdata: in_wdata, rd: in_rd};
                r_exc  <= w_misalign;
                r_data <= (in_store & ~w_misalign) ? 32'd0 : in_addr;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= LAT_CNT;
                if (!r_req.store) begin
                    r_data <= w_load_val;
                end
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign w_lane = r_req.funct3[0] ? 16'(mem_rdata >> {r_req.addr[1], 4'b0000})
                                    : 16'(mem_rdata >> {r_req.addr[1:0], 3'b000});

    always_comb begin
        if (r_req.funct3[1]) begin
            w_load_val = mem_rdata;
        end else if (r_req.funct3[0]) begin
            w_load_val = {{16{~r_req.funct3[2] & w_lane[15]}}, w_lane};
        end else begin
            w_load_val = {{24{~r_req.funct3[2] & w_lane[7]}}, w_lane[7:0]};
        end
    end

    always_comb begin
        if (r_req.funct3[1]) begin
            mem_wdata = r_req.wdata;
            mem_wstrb = 4'b1111;
        end else if (r_req.funct3[0]) begin
            mem_wdata = {16'd0, r_req.wdata[15:0]} << {r_req.addr[1], 4'b0000};
            mem_wstrb = 4'b0011 << {r_req.addr[1], 1'b0};
        end else begin
            mem_wdata = {24'd0, r_req.wdata[7:0]} << {r_req.addr[1:0], 3'b000};
            mem_wstrb = 4'b0001 << r_req.addr[1:0];
        end
    end

    assign mem_addr = {r_req.addr[31:2], 2'b00};
    assign out_data = r_data;
    assign out_rd   = r_req.rd;
    assign out_exc  = r_exc;

endmodule
